// File: rtl/mont_exp_ctrl.sv
// rtl/mont_exp_ctrl.sv - left-to-right square-and-multiply sequencer for a Montgomery multiplier
//
// Purpose: computes base^exp in the Montgomery domain. It issues one square
//   per exponent bit, MSB first, followed by a multiply by the base when the
//   bit is set. All modular arithmetic happens in the external multiplier.
//   This block only sequences operands and collects results.
//
// Build option: MEXP_CT_EN - constant-time schedule. A multiply is issued for
//   every bit, and its result is discarded when the bit is 0.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   start         one-cycle request, accepted only in IDLE
//   base_m        base in Montgomery form
//   one_m         Montgomery one (R mod m)
//   exp, m        exponent and odd modulus
//   busy          high from the cycle after acceptance through the done cycle
//   done          one-cycle completion pulse; res is valid from this cycle
//   res           result, held until the next run completes
//   mm_a, mm_b    multiplier operands, registered and held while an op runs
//   mm_m          multiplier modulus
//   mm_start      multiplier start pulse
//   mm_r, mm_vld  multiplier result and its one-cycle valid
module mont_exp_ctrl #(
  parameter int WID    = 256,
  parameter int CNTWID = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WID-1:0]    base_m,
  input  logic [WID-1:0]    one_m,
  input  logic [WID-1:0]    exp,
  input  logic [WID-1:0]    m,
  output logic              busy,
  output logic              done,
  output logic [WID-1:0]    res,
  output logic [WID-1:0]    mm_a,
  output logic [WID-1:0]    mm_b,
  output logic [WID-1:0]    mm_m,
  output logic              mm_start,
  input  logic [WID-1:0]    mm_r,
  input  logic              mm_vld
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SQ_ISS  = 3'd1,
    SQ_WAIT = 3'd2,
    MU_ISS  = 3'd3,
    MU_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [CNTWID-1:0] IDX_MSB = CNTWID'(WID - 1);

  state_t            state_q;
  logic [WID-1:0]    acc_q;
  logic [WID-1:0]    base_q;
  logic [WID-1:0]    exp_q;
  logic [WID-1:0]    m_q;
  logic [WID-1:0]    res_q;
  logic [WID-1:0]    mm_a_q;
  logic [WID-1:0]    mm_b_q;
  logic [CNTWID-1:0] idx_q;
  logic              busy_q;
  logic              done_q;
  logic              mm_start_q;

  logic              bit_set;
  logic              go_mul;
  logic              step_bit;
  logic [WID-1:0]    acc_d;

  assign bit_set = exp_q[idx_q];

`ifdef MEXP_CT_EN
  // Every bit runs a multiply so the op sequence does not leak the exponent.
  assign go_mul = 1'b1;
`else
  assign go_mul = bit_set;
`endif

  // acc_d is the accumulator after the current multiplier result is absorbed.
  // step_bit marks the point where the current bit is finished.
  always_comb begin
    acc_d    = acc_q;
    step_bit = 1'b0;
    if (mm_vld) begin
      case (state_q)
        SQ_WAIT: begin
          acc_d    = mm_r;
          step_bit = !go_mul;
        end
        MU_WAIT: begin
          // In the constant-time build a multiply on a 0 bit is a dummy.
          if (bit_set) acc_d = mm_r;
          step_bit = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      base_q     <= '0;
      exp_q      <= '0;
      m_q        <= '0;
      res_q      <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mm_start_q <= 1'b0;
    end else begin
      mm_start_q <= 1'b0;
      done_q     <= 1'b0;
      acc_q      <= acc_d;

      case (state_q)
        IDLE: begin
          if (start) begin
            base_q     <= base_m;
            exp_q      <= exp;
            m_q        <= m;
            acc_q      <= one_m;
            idx_q      <= IDX_MSB;
            // Operands are loaded here so that mm_start is high in SQ_ISS.
            mm_a_q     <= one_m;
            mm_b_q     <= one_m;
            mm_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SQ_ISS;
          end
        end
        SQ_ISS:  state_q <= SQ_WAIT;
        SQ_WAIT: begin
          if (mm_vld && go_mul) begin
            mm_a_q     <= acc_d;
            mm_b_q     <= base_q;
            mm_start_q <= 1'b1;
            state_q    <= MU_ISS;
          end
        end
        MU_ISS:  state_q <= MU_WAIT;
        MU_WAIT: ;
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Next-bit step. It is shared by both wait states and overrides the case above.
      if (step_bit) begin
        if (idx_q == '0) begin
          res_q   <= acc_d;
          done_q  <= 1'b1;
          state_q <= DONE;
        end else begin
          idx_q      <= idx_q - CNTWID'(1);
          mm_a_q     <= acc_d;
          mm_b_q     <= acc_d;
          mm_start_q <= 1'b1;
          state_q    <= SQ_ISS;
        end
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign res      = res_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_m     = m_q;
  assign mm_start = mm_start_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// tb/tb_mont_exp_ctrl.sv - directed bench for mont_exp_ctrl with m=13, R=16 and multiplier latency 6
module tb_mont_exp_ctrl;

  localparam int WID    = 4;
  localparam int CNTWID = 2;
  localparam int L      = 6;

`ifdef MEXP_CT_EN
  localparam int N_E5   = 8;
  localparam int N_E0   = 8;
  localparam int RST_OP = 4;
`else
  localparam int N_E5   = 6;
  localparam int N_E0   = 4;
  localparam int RST_OP = 3;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [WID-1:0] base_m, one_m, exp, m;
  logic           busy, done, mm_start, mm_vld;
  logic [WID-1:0] res, mm_a, mm_b, mm_m, mm_r;

  int checks = 0;
  int passed = 0;

  int op_cnt = 0;
  int overlap_cnt = 0;
  int stab_bad = 0;
  logic outstanding = 1'b0;
  logic [WID-1:0] la = '0, lb = '0;
  int mm_cnt = 0;

  always #5 clk = ~clk;

  mont_exp_ctrl #(.WID(WID), .CNTWID(CNTWID)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_m   (base_m),
    .one_m    (one_m),
    .exp      (exp),
    .m        (m),
    .busy     (busy),
    .done     (done),
    .res      (res),
    .mm_a     (mm_a),
    .mm_b     (mm_b),
    .mm_m     (mm_m),
    .mm_start (mm_start),
    .mm_r     (mm_r),
    .mm_vld   (mm_vld)
  );

  // Montgomery multiplier model: a*b*R^-1 mod 13, where R^-1 = 9 (16*9 = 144 = 11*13 + 1).
  always @(posedge clk) begin
    if (rst) begin
      mm_cnt <= 0;
      mm_vld <= 1'b0;
      mm_r   <= '0;
    end else begin
      mm_vld <= 1'b0;
      if (mm_start) begin
        mm_cnt <= L - 1;
        mm_r   <= 4'((int'(mm_a) * int'(mm_b) * 9) % 13);
      end else if (mm_cnt > 0) begin
        mm_cnt <= mm_cnt - 1;
        if (mm_cnt == 1) mm_vld <= 1'b1;
      end
    end
  end

  // Operand stability and single-outstanding-op monitor.
  always @(negedge clk) begin
    if (busy !== 1'b1) begin
      outstanding <= 1'b0;
    end else if (mm_start) begin
      if (outstanding) overlap_cnt <= overlap_cnt + 1;
      outstanding <= 1'b1;
      la          <= mm_a;
      lb          <= mm_b;
      op_cnt      <= op_cnt + 1;
    end else if (outstanding) begin
      if (mm_a !== la || mm_b !== lb) stab_bad <= stab_bad + 1;
      if (mm_vld) outstanding <= 1'b0;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // One run. The latency counts cycles from the start cycle through the done cycle, inclusive.
  task automatic run(input logic [WID-1:0] b, input logic [WID-1:0] e, input logic [WID-1:0] want,
                     input int nops, input bit disturb, input string tag);
    int  ops0;
    int  cyc;
    int  busy_bad;
    bit  got;
    base_m   = b;
    exp      = e;
    one_m    = 4'd3;
    m        = 4'd13;
    start    = 1'b1;
    ops0     = op_cnt;
    cyc      = 1;
    busy_bad = 0;
    got      = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick;
      cyc++;
      if (k == 0) start = 1'b0;
      if (disturb && k == 10) begin
        start  = 1'b1;
        base_m = 4'd1;
        exp    = 4'd15;
      end
      if (disturb && k == 11) start = 1'b0;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(2 + nops * (1 + L)));
    check({tag, "_res"}, 32'(res), 32'(want));
    check({tag, "_ops"}, 32'(op_cnt - ops0), 32'(nops));
    check({tag, "_busy_run"}, 32'(busy_bad), 32'd0);
    if (disturb) start = 1'b1;
    tick;
    start = 1'b0;
    check({tag, "_done_once"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ops0;
    int extra_done;
    rst    = 1'b1;
    start  = 1'b0;
    base_m = '0;
    one_m  = 4'd3;
    exp    = '0;
    m      = 4'd13;
    repeat (3) tick;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mm_start", 32'(mm_start), 32'd0);
    check("rst_res", 32'(res), 32'd0);
    check("rst_mm_a", 32'(mm_a), 32'd0);
    check("rst_mm_b", 32'(mm_b), 32'd0);
    check("rst_mm_m", 32'(mm_m), 32'd0);
    rst = 1'b0;
    tick;

    run(4'd6, 4'd5, 4'd5, N_E5, 1'b0, "b2e5");
    check("mm_m_latched", 32'(mm_m), 32'd13);
    run(4'd6, 4'd0, 4'd3, N_E0, 1'b0, "e0");
    run(4'd6, 4'd15, 4'd11, 8, 1'b0, "e15");
    run(4'd6, 4'd5, 4'd5, N_E5, 1'b1, "disturb");

    // Reset during the multiply of the second exponent bit (bit 2 of 4'b0101).
    base_m = 4'd6;
    exp    = 4'd5;
    start  = 1'b1;
    ops0   = op_cnt;
    tick;
    start  = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (op_cnt - ops0 >= RST_OP) break;
      tick;
    end
    check("rst_mid_reached", 32'(op_cnt - ops0), 32'(RST_OP));
    tick;
    tick;
    check("mid_mm_a", 32'(mm_a), 32'd3);
    check("mid_mm_b", 32'(mm_b), 32'd6);
    rst = 1'b1;
    tick;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_mm_start", 32'(mm_start), 32'd0);
    check("mid_rst_res", 32'(res), 32'd0);
    check("mid_rst_mm_m", 32'(mm_m), 32'd0);
    rst = 1'b0;
    extra_done = 0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (done !== 1'b0 || busy !== 1'b0) extra_done++;
    end
    check("mid_rst_quiet", 32'(extra_done), 32'd0);

    run(4'd6, 4'd15, 4'd11, 8, 1'b0, "post_rst");

    check("mm_overlap", 32'(overlap_cnt), 32'd0);
    check("mm_operand_stable", 32'(stab_bad), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
